// File: rtl/prio_sel_pipe.sv
// Fixed-priority (MSB-first) condition selector behind a 2-entry skid buffer.
// Optional saturating hit counter built when PRIO_SEL_HIT_CNT_EN is defined.
module prio_sel_pipe #(
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 8,
    localparam int IDX_W = $clog2(CTRL_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_hit,
    output logic [CTRL_W-1:0] out_onehot,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  hit_cnt
);

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic              hit;
        logic [CTRL_W-1:0] onehot;
    } res_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state;
    res_t   res, head, tail;
    logic   in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Ascending scan: the last set bit seen is the highest, matching an
    // MSB-first if/else-if chain.
    always_comb begin
        res = '0;
        for (int i = 0; i < CTRL_W; i++) begin
            if (in_ctrl[i]) begin
                res.idx = IDX_W'(i);
                res.hit = 1'b1;
            end
        end
        res.onehot = res.hit ? (CTRL_W'(1) << res.idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            head      <= '0;
            tail      <= '0;
        end else begin
            in_ready <= 1'b1;
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        head      <= res;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head <= res;
                    end else if (in_fire) begin
                        tail     <= res;
                        in_ready <= 1'b0;
                        state    <= TWO;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        head  <= tail;
                        state <= ONE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

    assign out_idx    = head.idx;
    assign out_hit    = head.hit;
    assign out_onehot = head.onehot;

`ifdef PRIO_SEL_HIT_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt)
            cnt <= '0;
        else if (out_fire && out_hit && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

    assign hit_cnt = cnt;
`else
    logic unused_clr;
    assign unused_clr = clr_cnt;
    assign hit_cnt    = '0;
`endif

endmodule

// File: tb/tb_prio_sel_pipe.sv
// Directed bench for prio_sel_pipe: reset, priority, backpressure, counter, mid-run reset.
module tb_prio_sel_pipe;
    localparam int CTRL_W = 4;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = $clog2(CTRL_W);
`ifdef PRIO_SEL_HIT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic              clk = 0;
    logic              rst_n;
    logic              in_valid, in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid, out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic              out_hit;
    logic [CTRL_W-1:0] out_onehot;
    logic              clr_cnt;
    logic [CNT_W-1:0]  hit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    prio_sel_pipe #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_hit(out_hit), .out_onehot(out_onehot),
        .clr_cnt(clr_cnt), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic h, input logic [IDX_W-1:0] i,
                           input logic [CTRL_W-1:0] oh);
        chk({tag, ".vld"}, 32'(out_valid), 32'd1);
        chk({tag, ".hit"}, 32'(out_hit), 32'(h));
        chk({tag, ".idx"}, 32'(out_idx), 32'(i));
        chk({tag, ".oh"},  32'(out_onehot), 32'(oh));
    endtask

    logic [CTRL_W-1:0] pv_ctrl [4];
    logic              pv_hit  [4];
    logic [IDX_W-1:0]  pv_idx  [4];
    logic [CTRL_W-1:0] pv_oh   [4];

    initial begin
        pv_ctrl = '{4'b0000, 4'b0001, 4'b0110, 4'b1011};
        pv_hit  = '{1'b0, 1'b1, 1'b1, 1'b1};
        pv_idx  = '{2'd0, 2'd0, 2'd2, 2'd3};
        pv_oh   = '{4'b0000, 4'b0001, 4'b0100, 4'b1000};

        // Reset held with a live input offered
        rst_n = 0; in_valid = 1; in_ctrl = 4'b1111; out_ready = 1; clr_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst.out_valid", 32'(out_valid), 0);
            chk("rst.in_ready",  32'(in_ready), 0);
            chk("rst.hit_cnt",   32'(hit_cnt), 0);
        end
        rst_n = 1; in_valid = 0;
        step();
        chk("rel.in_ready", 32'(in_ready), 1);
        chk("rel.out_valid", 32'(out_valid), 0);

        // Back-to-back priority resolution
        in_valid = 1; in_ctrl = pv_ctrl[0];
        for (int k = 0; k < 4; k++) begin
            step();
            chk_res($sformatf("prio%0d", k), pv_hit[k], pv_idx[k], pv_oh[k]);
            chk($sformatf("prio%0d.rdy", k), 32'(in_ready), 1);
            if (k < 3) in_ctrl = pv_ctrl[k+1];
            else in_valid = 0;
        end
        step();
        chk("prio.drain", 32'(out_valid), 0);

        // Backpressure: fill to TWO, third waits
        out_ready = 0; in_valid = 1; in_ctrl = 4'b0010;
        step();
        chk_res("bp.a", 1, 1, 4'b0010);
        chk("bp.a.rdy", 32'(in_ready), 1);
        in_ctrl = 4'b0100;
        step();
        chk("bp.b.rdy", 32'(in_ready), 0);
        chk_res("bp.b", 1, 1, 4'b0010);
        in_ctrl = 4'b1000;
        step();
        chk("bp.hold.rdy", 32'(in_ready), 0);
        chk_res("bp.hold", 1, 1, 4'b0010);
        out_ready = 1;
        step();
        chk_res("bp.pop1", 1, 2, 4'b0100);
        chk("bp.pop1.rdy", 32'(in_ready), 1);
        step();
        chk_res("bp.pop2", 1, 3, 4'b1000);
        in_valid = 0;
        step();
        chk("bp.empty", 32'(out_valid), 0);

        // Counter: saturation
        clr_cnt = 1;
        step();
        clr_cnt = 0;
        chk("cnt.clr0", 32'(hit_cnt), 0);
        in_valid = 1; in_ctrl = 4'b0001;
        for (int k = 0; k < 20; k++) step();
        in_valid = 0;
        step();
        chk("cnt.sat", 32'(hit_cnt), CNT_ON ? 32'd15 : 32'd0);
        chk("cnt.sat.vld", 32'(out_valid), 0);

        // clr_cnt beats a simultaneous hit fire
        in_valid = 1; in_ctrl = 4'b0001;
        step();
        chk("cnt.pre", 32'(hit_cnt), CNT_ON ? 32'd15 : 32'd0);
        in_valid = 0; clr_cnt = 1;
        step();
        clr_cnt = 0;
        chk("cnt.clrhit", 32'(hit_cnt), 0);

        // Non-hit transfers leave the count alone
        in_valid = 1; in_ctrl = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("nohit.hit", 32'(out_hit), 0);
        end
        in_valid = 0;
        step();
        chk("cnt.nohit", 32'(hit_cnt), 0);
        in_valid = 1; in_ctrl = 4'b0100;
        step();
        in_valid = 0;
        step();
        chk("cnt.one", 32'(hit_cnt), CNT_ON ? 32'd1 : 32'd0);

        // Reset while two entries are buffered
        out_ready = 0; in_valid = 1; in_ctrl = 4'b0010;
        step();
        in_ctrl = 4'b1000;
        step();
        chk("mid.full.rdy", 32'(in_ready), 0);
        rst_n = 0; in_valid = 0;
        step();
        chk("mid.rst.vld", 32'(out_valid), 0);
        chk("mid.rst.rdy", 32'(in_ready), 0);
        chk("mid.rst.idx", 32'(out_idx), 0);
        chk("mid.rst.hit", 32'(out_hit), 0);
        chk("mid.rst.oh",  32'(out_onehot), 0);
        chk("mid.rst.cnt", 32'(hit_cnt), 0);
        rst_n = 1; out_ready = 1;
        step();
        chk("mid.rel.rdy", 32'(in_ready), 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mid.nodrain", 32'(out_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
